// File: rtl/program_loader.sv
// program_loader: boot-stage loader that receives a framed byte stream
// (LEN_HI, LEN_LO, N x {HI,LO}, CHK) and writes the words into instruction
// memory. The CPU is held in reset through cpu_hold until a good load.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   in_valid/in_data  byte stream offered to the loader
//   in_ready          loader accepts a byte this cycle (state decode only)
//   start             re-arms the loader from DONE or ERR
//   im_we/im_addr/im_wdata  one-cycle instruction-memory write
//   cpu_hold          CPU reset, high while not DONE
//   done, err         load result
//   words_loaded      words written in the current load
module program_loader #(
  parameter int unsigned INSTR_W = 15,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  input  logic               start,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               err,
  output logic [ADDR_W:0]    words_loaded
);

  localparam int unsigned WL_W = ADDR_W + 1;
  localparam int unsigned CAP  = 32'd1 << ADDR_W;
  // HI bits above the instruction width are ignored everywhere, including
  // the running checksum.
  localparam logic [7:0] HI_MASK = 8'((32'd1 << (INSTR_W - 8)) - 32'd1);

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [7:0]          hi_q, hi_d;
  logic [7:0]          xor_q, xor_d;
  logic [WL_W-1:0]     wl_q, wl_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [INSTR_W-1:0]  wdata_q, wdata_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                rdy_q, rdy_d;

  logic                accept;
  logic [15:0]         len_new;
  logic [7:0]          hi_masked;

  // Next-state and next-output decode.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    hi_d      = hi_q;
    xor_d     = xor_q;
    wl_d      = wl_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    hold_d    = hold_q;
    done_d    = done_q;
    err_d     = err_q;
    accept    = in_valid && rdy_q;
    len_new   = {len_q[15:8], in_data};
    hi_masked = in_data & HI_MASK;

    unique case (state_q)
      S_LEN_HI: if (accept) begin
        len_d   = {in_data, len_q[7:0]};
        xor_d   = xor_q ^ in_data;
        state_d = S_LEN_LO;
      end
      S_LEN_LO: if (accept) begin
        len_d = len_new;
        xor_d = xor_q ^ in_data;
        if (len_new == 16'd0 || 32'(len_new) > CAP) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: if (accept) begin
        hi_d    = hi_masked;
        xor_d   = xor_q ^ hi_masked;
        state_d = S_DATA_LO;
      end
      S_DATA_LO: if (accept) begin
        xor_d   = xor_q ^ in_data;
        we_d    = 1'b1;
        addr_d  = wl_q[ADDR_W-1:0];
        wdata_d = INSTR_W'({hi_q, in_data});
        wl_d    = wl_q + WL_W'(1);
        if (32'(wl_q) + 32'd1 == 32'(len_q)) state_d = S_CHK;
        else                                 state_d = S_DATA_HI;
      end
      S_CHK: if (accept) begin
        if (in_data == xor_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          hold_d  = 1'b0;
        end else begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
      S_DONE, S_ERR: if (start) begin
        state_d = S_LEN_HI;
        done_d  = 1'b0;
        err_d   = 1'b0;
        hold_d  = 1'b1;
        wl_d    = '0;
        xor_d   = 8'd0;
      end
      default: state_d = S_LEN_HI;
    endcase

    // Registered from next state, so it is a pure decode of the current state.
    rdy_d = (state_d != S_DONE) && (state_d != S_ERR);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LEN_HI;
      len_q   <= 16'd0;
      hi_q    <= 8'd0;
      xor_q   <= 8'd0;
      wl_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      xor_q   <= xor_d;
      wl_q    <= wl_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready     = rdy_q;
  assign im_we        = we_q;
  assign im_addr      = addr_q;
  assign im_wdata     = wdata_q;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = wl_q;

endmodule
